// File: rtl/riscv_mdu_pkg.sv
// Shared constants and types for the RISC-V M-extension issue unit:
// major opcodes, the MULDIV funct7 value, the eight funct3 operation codes
// and the issue FSM state encoding.
package riscv_mdu_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP32   = 7'b0111011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/riscv_mdu_decode.sv
// Combinational decode of OP / OP-32 instruction fields into an M-extension
// legality flag and the 32-bit (W-suffix) operation flag. OP-32 has no
// high-half multiplies, so only MULW/DIVW/DIVUW/REMW/REMUW are legal there.
module riscv_mdu_decode
    import riscv_mdu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output logic       legal,
    output logic       is_32bit
);

    // Legality: MULDIV funct7 with either major opcode, restricted funct3 on OP-32
    always_comb begin
        legal    = 1'b0;
        is_32bit = (opcode == OPCODE_OP32);
        if (funct7 == FUNCT7_MULDIV) begin
            if (opcode == OPCODE_OP) begin
                legal = 1'b1;
            end else if (opcode == OPCODE_OP32) begin
                case (funct3)
                    F3_MUL, F3_DIV, F3_DIVU, F3_REM, F3_REMU: legal = 1'b1;
                    default:                                   legal = 1'b0;
                endcase
            end
        end
    end

endmodule

// File: rtl/riscv_mdu_issue.sv
// Issue unit between the pipeline and a multi-cycle multiply/divide unit.
// Accepts one OP/OP-32 instruction at a time, forwards it to the MDU for a
// single cycle, waits for the result and writes it back. A flush while the
// MDU is busy moves to DRAIN so the late result is swallowed.
// Optional watchdog: define RISCV_MDU_ISSUE_TIMEOUT_EN to abandon an
// instruction after TIMEOUT_CYCLES cycles without mdu_valid.
module riscv_mdu_issue
    import riscv_mdu_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [6:0]      req_opcode,
    input  logic [6:0]      req_funct7,
    input  logic [2:0]      req_funct3,
    input  logic [4:0]      req_rd,
    input  logic [XLEN-1:0] req_rs1_data,
    input  logic [XLEN-1:0] req_rs2_data,
    input  logic            flush,
    output logic            stall,
    output logic            mdu_enable,
    output logic [2:0]      mdu_funct3,
    output logic            mdu_is_32bit,
    output logic [XLEN-1:0] mdu_rs1_data,
    output logic [XLEN-1:0] mdu_rs2_data,
    input  logic            mdu_valid,
    input  logic [XLEN-1:0] mdu_result,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            done,
    output logic            illegal,
    output logic            timeout
);

    state_t state_reg;
    state_t state_next;
    logic   accept;
    logic   dec_legal;
    logic   dec_is_32bit;
    logic   timeout_hit;
    logic [4:0] rd_reg;

    riscv_mdu_decode u_decode (
        .opcode   (req_opcode),
        .funct7   (req_funct7),
        .funct3   (req_funct3),
        .legal    (dec_legal),
        .is_32bit (dec_is_32bit)
    );

`ifdef RISCV_MDU_ISSUE_TIMEOUT_EN
    // Counter only needs to reach TIMEOUT_CYCLES-1 before the watchdog fires
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_reg;

    assign timeout_hit = ((state_reg == ST_WAIT) || (state_reg == ST_DRAIN)) &&
                         !mdu_valid && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: cleared when the request goes out, counts while waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= timeout_hit;
            if (state_reg == ST_SEND) begin
                cnt_reg <= '0;
            end else if ((state_reg == ST_WAIT) || (state_reg == ST_DRAIN)) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end
`else
    // Watchdog compiled out: wait for the MDU indefinitely
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
    assign timeout            = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; in WAIT a returning result or flush both end the wait,
    // but only a flush without a result needs DRAIN to absorb the late response
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept && dec_legal) state_next = ST_SEND;
            ST_SEND:  state_next = flush ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                if (mdu_valid || timeout_hit) state_next = ST_IDLE;
                else if (flush)               state_next = ST_DRAIN;
            end
            ST_DRAIN: if (mdu_valid || timeout_hit) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Handshake and MDU strobe outputs decoded from the current state
    always_comb begin
        req_ready  = (state_reg == ST_IDLE) && !flush;
        accept     = req_valid && req_ready;
        stall      = (state_reg != ST_IDLE) || accept;
        mdu_enable = (state_reg == ST_SEND) && !flush;
    end

    // Request capture, writeback registers and one-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_funct3   <= 3'd0;
            mdu_is_32bit <= 1'b0;
            mdu_rs1_data <= '0;
            mdu_rs2_data <= '0;
            rd_reg       <= 5'd0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= '0;
            done         <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            if (accept && dec_legal) begin
                mdu_funct3   <= req_funct3;
                mdu_is_32bit <= dec_is_32bit;
                mdu_rs1_data <= req_rs1_data;
                mdu_rs2_data <= req_rs2_data;
                rd_reg       <= req_rd;
            end
            if (accept && !dec_legal) begin
                illegal <= 1'b1;
                done    <= 1'b1;
            end
            if ((state_reg == ST_WAIT) && mdu_valid && !flush) begin
                wb_valid <= (rd_reg != 5'd0);
                wb_rd    <= rd_reg;
                wb_data  <= mdu_result;
                done     <= 1'b1;
            end
            if (timeout_hit && (state_reg == ST_WAIT) && !flush) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_mdu_issue.sv
// Scoreboard bench for riscv_mdu_issue. The bench plays the MDU (MUL family
// answers one cycle after mdu_enable, DIV/REM family four cycles after),
// computes results from RISC-V M-extension arithmetic, and checks every
// completion pulse against expectations queued at issue time.
// With RISCV_MDU_ISSUE_TIMEOUT_EN defined a watchdog scenario is added.
module tb_riscv_mdu_issue;

    localparam int XLEN = 64;
    localparam int TMO  = 4;
    localparam logic [6:0] OP   = 7'b0110011;
    localparam logic [6:0] OP32 = 7'b0111011;

    typedef struct {
        int          kind;   // 0 result, 1 illegal, 2 timeout
        logic [4:0]  rd;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [6:0]      req_opcode = '0;
    logic [6:0]      req_funct7 = '0;
    logic [2:0]      req_funct3 = '0;
    logic [4:0]      req_rd = '0;
    logic [XLEN-1:0] req_rs1_data = '0;
    logic [XLEN-1:0] req_rs2_data = '0;
    logic            flush = 1'b0;
    logic            stall;
    logic            mdu_enable;
    logic [2:0]      mdu_funct3;
    logic            mdu_is_32bit;
    logic [XLEN-1:0] mdu_rs1_data;
    logic [XLEN-1:0] mdu_rs2_data;
    logic            mdu_valid = 1'b0;
    logic [XLEN-1:0] mdu_result = '0;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            done;
    logic            illegal;
    logic            timeout;

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    bit   mdu_mute = 1'b0;
    exp_t exp_q[$];

    riscv_mdu_issue #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_funct7(req_funct7),
        .req_funct3(req_funct3), .req_rd(req_rd),
        .req_rs1_data(req_rs1_data), .req_rs2_data(req_rs2_data),
        .flush(flush), .stall(stall),
        .mdu_enable(mdu_enable), .mdu_funct3(mdu_funct3),
        .mdu_is_32bit(mdu_is_32bit),
        .mdu_rs1_data(mdu_rs1_data), .mdu_rs2_data(mdu_rs2_data),
        .mdu_valid(mdu_valid), .mdu_result(mdu_result),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .done(done), .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit ref_legal(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3);
        if (f7 != 7'b0000001) return 1'b0;
        if (op == OP) return 1'b1;
        if (op == OP32) return (f3 == 3'd0) || (f3 >= 3'd4);
        return 1'b0;
    endfunction

    // RISC-V M-extension results, including divide-by-zero and overflow cases
    function automatic logic [63:0] ref_mdu(input logic [2:0] f3, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  a32, b32, r32;
        logic         ovf;
        if (!w) begin
            ovf = (a == 64'h8000_0000_0000_0000) && (b == '1);
            case (f3)
                3'd0: return a * b;
                3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
                3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
                3'd3: begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
                3'd4: return (b == 0) ? '1 : ovf ? a : $signed(a) / $signed(b);
                3'd5: return (b == 0) ? '1 : a / b;
                3'd6: return (b == 0) ? a : ovf ? 64'd0 : $signed(a) % $signed(b);
                default: return (b == 0) ? a : a % b;
            endcase
        end
        a32 = a[31:0];
        b32 = b[31:0];
        ovf = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
        case (f3)
            3'd0: r32 = a32 * b32;
            3'd4: r32 = (b32 == 0) ? 32'hFFFF_FFFF : ovf ? a32 : $signed(a32) / $signed(b32);
            3'd5: r32 = (b32 == 0) ? 32'hFFFF_FFFF : a32 / b32;
            3'd6: r32 = (b32 == 0) ? a32 : ovf ? 32'd0 : $signed(a32) % $signed(b32);
            default: r32 = (b32 == 0) ? a32 : a32 % b32;
        endcase
        return {{32{r32[31]}}, r32};
    endfunction

    // MDU model: samples the request, answers after the family latency
    initial begin
        logic [63:0] res;
        int lat;
        forever begin
            @(negedge clk);
            if (rst_n && mdu_enable && !mdu_mute) begin
                res = ref_mdu(mdu_funct3, mdu_is_32bit, mdu_rs1_data, mdu_rs2_data);
                lat = mdu_funct3[2] ? 4 : 1;
                repeat (lat) @(negedge clk);
                mdu_result = res;
                mdu_valid  = 1'b1;
                @(negedge clk);
                mdu_valid  = 1'b0;
                mdu_result = '0;
            end
        end
    end

    // Monitor: every completion pulse is matched against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (done || wb_valid || illegal || timeout)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {60'd0, done, wb_valid, illegal, timeout}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_cycle", cyc, e.cyc);
                    check("done", done, 1);
                    check("illegal", illegal, e.kind == 1);
                    check("timeout", timeout, e.kind == 2);
                    check("wb_valid", wb_valid, (e.kind == 0) && (e.rd != 0));
                    if ((e.kind == 0) && (e.rd != 0)) begin
                        check("wb_rd", wb_rd, e.rd);
                        check("wb_data", wb_data, e.data);
                    end
                end
            end
        end
    end

    // Present one instruction, optionally flush it k cycles after acceptance,
    // and check when the unit becomes ready again
    task automatic issue(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [63:0] a, input logic [63:0] b,
                         input int flush_off, input bit mute);
        int   acc, exp_ready, ready_k;
        bit   lg, dv;
        exp_t e;
        lg = ref_legal(op, f7, f3);
        dv = f3[2];
        req_opcode = op; req_funct7 = f7; req_funct3 = f3; req_rd = rd;
        req_rs1_data = a; req_rs2_data = b; req_valid = 1'b1; flush = 1'b0;
        #1;
        check("req_ready", req_ready, 1);
        check("stall_on_accept", stall, 1);
        acc = cyc;
        e.rd = rd; e.data = ref_mdu(f3, op == OP32, a, b);
        if (!lg) begin
            e.kind = 1; e.cyc = acc + 1; exp_q.push_back(e);
        end else if (flush_off == 0) begin
            e.kind = mute ? 2 : 0;
            e.cyc  = mute ? acc + 2 + TMO : acc + (dv ? 6 : 3);
            exp_q.push_back(e);
        end
        exp_ready = !lg ? 1 : (flush_off == 1) ? 2 : mute ? 2 + TMO : dv ? 6 : 3;
        $display("issue cyc=%0d op=%b f7=%b f3=%0d rd=%0d a=%h b=%h flush_at=%0d legal=%0d",
                 acc, op, f7, f3, rd, a, b, flush_off, lg);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_rs1_data = {$urandom, $urandom};
        req_rs2_data = {$urandom, $urandom};
        ready_k = -1;
        for (int k = 1; k <= 40; k++) begin
            flush = (k == flush_off);
            #1;
            if (k == 1) check("mdu_enable_c1", mdu_enable, lg && (flush_off != 1));
            if (k == 2) check("mdu_enable_c2", mdu_enable, 0);
            if (req_ready) begin
                ready_k = k;
                break;
            end
            @(posedge clk); #1;
        end
        flush = 1'b0;
        check("ready_cycle", ready_k, exp_ready);
    endtask

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return {32'($urandom), 32'h8000_0000};
            4: return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench watchdog");
    end

    initial begin
        logic [6:0] op, f7;
        logic [2:0] f3;
        int fo;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wb_valid", wb_valid, 0);
        check("rst_done", done, 0);
        check("rst_illegal", illegal, 0);
        check("rst_timeout", timeout, 0);
        check("rst_mdu_enable", mdu_enable, 0);
        check("rst_mdu_is_32bit", mdu_is_32bit, 0);
        check("rst_mdu_funct3", mdu_funct3, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_mdu_rs1", mdu_rs1_data, 0);
        check("rst_mdu_rs2", mdu_rs2_data, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_stall", stall, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Flush in IDLE blocks acceptance
        req_valid = 1'b1; req_opcode = OP; req_funct7 = 7'b0000001; req_rd = 5'd9;
        flush = 1'b1;
        #1;
        check("flush_idle_ready", req_ready, 0);
        check("flush_idle_stall", stall, 0);
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        #1;
        check("flush_idle_not_taken", req_ready, 1);

        // Directed cases
        issue(OP,   7'b0000001, 3'd0, 5'd5, 64'd6, 64'd7, 0, 0);   // MUL 6*7
        issue(OP,   7'b0000001, 3'd5, 5'd3, 64'd7, 64'd0, 0, 0);   // DIVU by zero
        issue(OP32, 7'b0000001, 3'd1, 5'd4, 64'd3, 64'd5, 0, 0);   // MULHW illegal
        issue(OP,   7'b0000001, 3'd4, 5'd6, 64'd100, 64'd7, 3, 0); // DIV, flush into DRAIN
        issue(OP,   7'b0000001, 3'd0, 5'd0, 64'd2, 64'd3, 0, 0);   // MUL to x0
        issue(OP,   7'b0000001, 3'd0, 5'd7, 64'd2, 64'd3, 1, 0);   // flush in SEND
        issue(OP,   7'b0000001, 3'd3, 5'd8, '1, '1, 2, 0);         // flush with result
        issue(OP,   7'b0000001, 3'd6, 5'd9, 64'd9, 64'd4, 5, 0);   // flush with result
        issue(OP32, 7'b0000001, 3'd4, 5'd10, 64'h8000_0000, 64'hFFFF_FFFF, 0, 0); // DIVW ovf
        issue(OP,   7'b0000000, 3'd0, 5'd11, 64'd1, 64'd1, 0, 0);  // plain ADD, not M

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0:       begin op = 7'($urandom); f7 = 7'b0000001; end
                1:       begin op = OP; f7 = 7'($urandom_range(2, 127)); end
                2, 3, 4, 5: begin op = OP; f7 = 7'b0000001; end
                default: begin op = OP32; f7 = 7'b0000001; end
            endcase
            f3 = 3'($urandom_range(0, 7));
            fo = 0;
            if (ref_legal(op, f7, f3) && ($urandom_range(0, 3) == 0))
                fo = f3[2] ? $urandom_range(1, 5) : $urandom_range(1, 2);
            issue(op, f7, f3, 5'($urandom), rnd_operand(), rnd_operand(), fo, 0);
        end

`ifdef RISCV_MDU_ISSUE_TIMEOUT_EN
        mdu_mute = 1'b1;
        issue(OP, 7'b0000001, 3'd4, 5'd12, 64'd50, 64'd5, 0, 1);
        mdu_mute = 1'b0;
        #1;
        check("timeout_idle", req_ready, 1);
`endif

        // Reset in the middle of a DIV abandons it silently
        req_opcode = OP; req_funct7 = 7'b0000001; req_funct3 = 3'd4; req_rd = 5'd13;
        req_rs1_data = 64'd77; req_rs2_data = 64'd7; req_valid = 1'b1;
        $display("issue cyc=%0d DIV then reset mid-operation", cyc);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", req_ready, 1);
        check("midrst_stall", stall, 0);
        check("midrst_enable", mdu_enable, 0);
        check("midrst_funct3", mdu_funct3, 0);
        check("midrst_rs1", mdu_rs1_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_ready_after", req_ready, 1);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
